// File: rtl/scratchpad_mem_responder.sv
// Scratchpad memory responder: answers single-word host read/write requests from an internal word array.
// Latency: strobe in cycle N -> one-cycle ready pulse in cycle N+LATENCY+1 when idle (write wins ties).
// Backpressure: none; one pending slot per direction, a strobe into a full slot overwrites it and sets err.
module scratchpad_mem_responder #(
    parameter int                   ADDR_WID = 12,
    parameter int                   DATA_WID = 32,
    parameter int                   LATENCY  = 3,
    parameter logic [DATA_WID-1:0]  ERR_DATA = 32'hDEADBEEF
) (
    input  logic                mod_clk,
    input  logic                reset,
    input  logic [63:0]         base_addr,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic [63:0]         read_size,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [63:0]         write_size,
    input  logic [DATA_WID-1:0] write_data,
    input  logic                ld_en,
    input  logic [ADDR_WID-1:0] ld_addr,
    input  logic [DATA_WID-1:0] ld_data,
    output logic [63:0]         read_ready,
    output logic [DATA_WID-1:0] read_data,
    output logic [63:0]         write_ready,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic                err
);

    localparam int         DEPTH    = 2 ** ADDR_WID;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_WAIT  = 2'd1;
    localparam logic [1:0] WR_WAIT  = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
    localparam bit         LAT_ONE  = (LATENCY == 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be within 1..15");
    end

    logic [1:0]          state;
    logic [3:0]          lat_cnt;
    logic [DATA_WID-1:0] mem [DEPTH];

    // Pending request slots, one per direction.
    logic                pend_rd_vld, pend_rd_ok;
    logic [ADDR_WID-1:0] pend_rd_idx;
    logic                pend_wr_vld, pend_wr_ok;
    logic [ADDR_WID-1:0] pend_wr_idx;
    logic [DATA_WID-1:0] pend_wr_dat;

    // Request being served; copied out of its slot when selected so the slot can accept the next one.
    logic                act_wr, act_ok;
    logic [ADDR_WID-1:0] act_idx;
    logic [DATA_WID-1:0] act_dat;

    logic                srv_wr, srv_ok;
    logic [ADDR_WID-1:0] srv_idx;
    logic [DATA_WID-1:0] srv_dat;

    logic        rd_pulse, wr_pulse;
    logic [63:0] rd_off, wr_off;
    logic        rd_ok, wr_ok;
    logic        take_rd, take_wr, fire, fire_rd, fire_wr, ld_ok;

    // Byte address decode: in range, word aligned, single 4-byte word.
    assign rd_off = read_addr - base_addr;
    assign wr_off = write_addr - base_addr;
    assign rd_ok  = (read_addr >= base_addr) && (rd_off[1:0] == 2'b00) &&
                    (rd_off[63:ADDR_WID+2] == '0) && (read_size == 64'd4);
    assign wr_ok  = (write_addr >= base_addr) && (wr_off[1:0] == 2'b00) &&
                    (wr_off[63:ADDR_WID+2] == '0) && (write_size == 64'd4);

    assign take_wr = (state == IDLE) && pend_wr_vld;
    assign take_rd = (state == IDLE) && !pend_wr_vld && pend_rd_vld;
    assign fire    = (LAT_ONE && (take_wr || take_rd)) ||
                     (((state == RD_WAIT) || (state == WR_WAIT)) && (lat_cnt == 4'd1));
    assign fire_rd = fire && !srv_wr;
    assign fire_wr = fire && srv_wr;
    assign ld_ok   = (state == IDLE) && !pend_rd_vld && !pend_wr_vld;

    assign read_ready  = {63'd0, rd_pulse};
    assign write_ready = {63'd0, wr_pulse};

    // Serve straight from the slot on the selecting cycle (needed when LATENCY is 1), else from the active copy.
    always_comb begin
        srv_wr  = act_wr;
        srv_ok  = act_ok;
        srv_idx = act_idx;
        srv_dat = act_dat;
        if (take_wr) begin
            srv_wr  = 1'b1;
            srv_ok  = pend_wr_ok;
            srv_idx = pend_wr_idx;
            srv_dat = pend_wr_dat;
        end else if (take_rd) begin
            srv_wr  = 1'b0;
            srv_ok  = pend_rd_ok;
            srv_idx = pend_rd_idx;
        end
    end

    // Sequencer: select a request, count out the latency, spend one cycle in RESP.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            act_wr  <= 1'b0;
            act_ok  <= 1'b0;
            act_idx <= '0;
            act_dat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_wr || take_rd) begin
                        act_wr  <= srv_wr;
                        act_ok  <= srv_ok;
                        act_idx <= srv_idx;
                        act_dat <= srv_dat;
                        lat_cnt <= LAT_LOAD;
                        if (LAT_ONE)      state <= RESP;
                        else if (take_wr) state <= WR_WAIT;
                        else              state <= RD_WAIT;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pending slots: a new strobe always loads; selection frees the slot.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            pend_rd_vld <= 1'b0;
            pend_rd_ok  <= 1'b0;
            pend_rd_idx <= '0;
            pend_wr_vld <= 1'b0;
            pend_wr_ok  <= 1'b0;
            pend_wr_idx <= '0;
            pend_wr_dat <= '0;
        end else begin
            if (read_enable) begin
                pend_rd_vld <= 1'b1;
                pend_rd_ok  <= rd_ok;
                pend_rd_idx <= rd_off[ADDR_WID+1:2];
            end else if (take_rd) begin
                pend_rd_vld <= 1'b0;
            end
            if (write_enable) begin
                pend_wr_vld <= 1'b1;
                pend_wr_ok  <= wr_ok;
                pend_wr_idx <= wr_off[ADDR_WID+1:2];
                pend_wr_dat <= write_data;
            end else if (take_wr) begin
                pend_wr_vld <= 1'b0;
            end
        end
    end

    // Responses: registered ready pulses, read data capture, completion counters, sticky error.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            rd_pulse  <= 1'b0;
            wr_pulse  <= 1'b0;
            read_data <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            err       <= 1'b0;
        end else begin
            rd_pulse <= fire_rd;
            wr_pulse <= fire_wr;
            if (fire_rd) begin
                read_data <= srv_ok ? mem[srv_idx] : ERR_DATA;
                rd_count  <= rd_count + 32'd1;
            end
            if (fire_wr) wr_count <= wr_count + 32'd1;
            if ((read_enable && (!rd_ok || pend_rd_vld)) ||
                (write_enable && (!wr_ok || pend_wr_vld)) ||
                (ld_en && !ld_ok))
                err <= 1'b1;
        end
    end

    // Single write port shared by response writes and backdoor preload; they never coincide.
    always_ff @(posedge mod_clk) begin
        if (fire_wr && srv_ok)    mem[srv_idx] <= srv_dat;
        else if (ld_en && ld_ok)  mem[ld_addr] <= ld_data;
    end

endmodule
